rst_seq: RTL and testbench

Reset release sequencer that sits directly downstream of the pad-level reset synchronizer. It takes the already-synchronized active-low reset and releases NUM_DOM reset domains one at a time, spaced by a fixed delay. Example release order: memories/clocking, then the PicoRV32 core, then peripherals and the approximation units. It also provides a software-requested re-sequence through a req/ack handshake.

---
 rtl/rst_seq.sv | 158 +++++++++++++++
 tb/tb_rst_seq.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
// rst_seq : staged reset-release sequencer with a soft re-sequence handshake.
//           Optional run-time watchdog enabled by defining RST_SEQ_WDT_EN.
// Revision : 1.0
// ============================================================================
module rst_seq #(
  parameter int NUM_DOM    = 3,
  parameter int STAGE_DLY  = 16,
  parameter int SW_RST_CYC = 8
`ifdef RST_SEQ_WDT_EN
  ,
  parameter int WDT_CYC    = 1024
`endif
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               soft_rst_req,
`ifdef RST_SEQ_WDT_EN
  input  logic               wdt_kick,
  output logic               wdt_fired,
`endif
  output logic               soft_rst_ack,
  output logic [NUM_DOM-1:0] dom_rstn,
  output logic               seq_done,
  output logic [1:0]         seq_state
);

  localparam int MAX_DLY = (STAGE_DLY > SW_RST_CYC) ? STAGE_DLY : SW_RST_CYC;
  localparam int CNT_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;
  localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(SW_RST_CYC - 1);
  localparam logic [CNT_W-1:0] C_STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST   = IDX_W'(NUM_DOM - 1);

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_REL  = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               soft_q;
  logic               ack_q;
  logic               done_q;
  logic [NUM_DOM-1:0] dom_q;
  logic [NUM_DOM-1:0] rel_mask_d;
  logic               soft_take_d;
  logic               wdt_expire_d;
  logic               restart_d;

  // A request seen on the ack cycle belongs to the sequence just finished.
  assign soft_take_d = soft_rst_req && !ack_q;
  assign restart_d   = (state_q == ST_RUN) && (soft_take_d || wdt_expire_d);

`ifdef RST_SEQ_WDT_EN
  localparam int WDT_W = (WDT_CYC > 1) ? $clog2(WDT_CYC) : 1;
  localparam logic [WDT_W-1:0] C_WDT_LAST = WDT_W'(WDT_CYC - 1);

  logic [WDT_W-1:0] wdt_q;
  logic             fired_q;

  // A kick in the expiry cycle wins over the timeout.
  assign wdt_expire_d = (state_q == ST_RUN) && (wdt_q == C_WDT_LAST) && !wdt_kick;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wdt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      if ((state_q != ST_RUN) || restart_d || wdt_kick) begin
        wdt_q <= '0;
      end else begin
        wdt_q <= wdt_q + WDT_W'(1);
      end
      if (wdt_expire_d) begin
        fired_q <= 1'b1;
      end
    end
  end

  assign wdt_fired = fired_q;
`else
  assign wdt_expire_d = 1'b0;
`endif

  always_comb begin
    rel_mask_d = '0;
    for (int k = 0; k < NUM_DOM; k++) begin
      if (idx_q == IDX_W'(k)) begin
        rel_mask_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      soft_q  <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      dom_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == C_HOLD_LAST) begin
            state_q <= ST_REL;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_REL: begin
          if (cnt_q == C_STAGE_LAST) begin
            cnt_q <= '0;
            idx_q <= idx_q + IDX_W'(1);
            dom_q <= dom_q | rel_mask_d;
            if (idx_q == C_IDX_LAST) begin
              state_q <= ST_RUN;
              done_q  <= 1'b1;
              ack_q   <= soft_q;
              soft_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (restart_d) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            dom_q   <= '0;
            done_q  <= 1'b0;
            soft_q  <= soft_take_d;
          end
        end
        default: begin
          state_q <= ST_HOLD;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign dom_rstn     = dom_q;
  assign seq_done     = done_q;
  assign soft_rst_ack = ack_q;
  assign seq_state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ============================================================================
// tb_rst_seq : self-checking bench for rst_seq (table, directed and random).
// Revision : 1.0
// ============================================================================
module tb_rst_seq;

  localparam int N  = 3;
  localparam int SD = 16;
  localparam int SW = 8;
  localparam int T  = SW + N * SD;
`ifdef RST_SEQ_WDT_EN
  localparam int WDT = 100;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         arstn = 1'b0;
  logic         req   = 1'b0;
  logic [N-1:0] dom;
  logic         done;
  logic         ack;
  logic [1:0]   st;

  logic         arstn_b = 1'b0;
  logic         req_b   = 1'b0;
  logic [0:0]   dom_b;
  logic         done_b;
  logic         ack_b;
  logic [1:0]   st_b;

`ifdef RST_SEQ_WDT_EN
  logic kick   = 1'b0;
  logic kick_b = 1'b1;
  logic fired;
  logic fired_b;
`endif

  rst_seq #(
    .NUM_DOM(N), .STAGE_DLY(SD), .SW_RST_CYC(SW)
`ifdef RST_SEQ_WDT_EN
    , .WDT_CYC(WDT)
`endif
  ) u_dut (
    .clk(clk), .arstn(arstn), .soft_rst_req(req),
`ifdef RST_SEQ_WDT_EN
    .wdt_kick(kick), .wdt_fired(fired),
`endif
    .soft_rst_ack(ack), .dom_rstn(dom), .seq_done(done), .seq_state(st)
  );

  rst_seq #(
    .NUM_DOM(1), .STAGE_DLY(1), .SW_RST_CYC(1)
  ) u_dut_b (
    .clk(clk), .arstn(arstn_b), .soft_rst_req(req_b),
`ifdef RST_SEQ_WDT_EN
    .wdt_kick(kick_b), .wdt_fired(fired_b),
`endif
    .soft_rst_ack(ack_b), .dom_rstn(dom_b), .seq_done(done_b), .seq_state(st_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt  = 0;

  // Reference model: cycles elapsed since the current sequence started.
  int m_t    = 0;
  bit m_soft = 1'b0;
  int m_idle = 0;
  bit m_fired = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_dom(input int t);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = (t >= SW + (k + 1) * SD);
    return r;
  endfunction

  function automatic logic [1:0] exp_st(input int t);
    if (t < SW) return 2'd0;
    if (t < T)  return 2'd1;
    return 2'd2;
  endfunction

  task automatic mdl_reset();
    m_t = 0; m_soft = 1'b0; m_idle = 0; m_fired = 1'b0;
  endtask

  task automatic mdl_edge();
    bit run, ack_now, take, wexp;
    if (!arstn) begin
      mdl_reset();
      return;
    end
    run     = (m_t >= T);
    ack_now = m_soft && (m_t == T);
    take    = req && !ack_now;
    wexp    = 1'b0;
`ifdef RST_SEQ_WDT_EN
    if (!run || kick)         m_idle = 0;
    else if (m_idle == WDT-1) wexp = 1'b1;
    else                      m_idle++;
`endif
    if (run && (take || wexp)) begin
      m_t    = 0;
      m_soft = take;
      m_idle = 0;
      if (wexp) m_fired = 1'b1;
    end else if (m_t <= T) begin
      m_t++;
    end
  endtask

  task automatic chk_model();
    check("mdl_dom",  32'(dom),  32'(exp_dom(m_t)));
    check("mdl_done", 32'(done), 32'(m_t >= T));
    check("mdl_ack",  32'(ack),  32'(m_soft && m_t == T));
    check("mdl_st",   32'(st),   32'(exp_st(m_t)));
`ifdef RST_SEQ_WDT_EN
    check("mdl_fired", 32'(fired), 32'(m_fired));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    mdl_edge();
    ecnt++;
    #1;
    chk_model();
  endtask

  task automatic run_to(input int e);
    while (ecnt < e) step();
  endtask

  task automatic fresh_start();
    arstn = 1'b0;
    mdl_reset();
    #1;
    step();
    arstn = 1'b1;
    ecnt  = 0;
  endtask

  typedef struct {
    int         ed;
    logic [2:0] dom;
    logic       done;
    logic       ack;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[10];
  int   e0;

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{1,  3'b000, 1'b0, 1'b0, 2'd0},
      '{7,  3'b000, 1'b0, 1'b0, 2'd0},
      '{8,  3'b000, 1'b0, 1'b0, 2'd1},
      '{23, 3'b000, 1'b0, 1'b0, 2'd1},
      '{24, 3'b001, 1'b0, 1'b0, 2'd1},
      '{39, 3'b001, 1'b0, 1'b0, 2'd1},
      '{40, 3'b011, 1'b0, 1'b0, 2'd1},
      '{55, 3'b011, 1'b0, 1'b0, 2'd1},
      '{56, 3'b111, 1'b1, 1'b0, 2'd2},
      '{60, 3'b111, 1'b1, 1'b0, 2'd2}
    };
    mdl_reset();
    repeat (3) step();
    check("rst_dom",  32'(dom),  32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack",  32'(ack),  32'd0);
    check("rst_st",   32'(st),   32'd0);

    // Pass 1 also holds req during HOLD/REL, which must be ignored.
    for (int pass = 0; pass < 2; pass++) begin
      fresh_start();
      for (int i = 0; i < 10; i++) begin
        while (ecnt < tbl[i].ed) begin
          req = (pass == 1) && (ecnt + 1 >= 10) && (ecnt + 1 <= 50);
          step();
        end
        check($sformatf("tbl%0d_%0d_dom", pass, i),  32'(dom),  32'(tbl[i].dom));
        check($sformatf("tbl%0d_%0d_done", pass, i), 32'(done), 32'(tbl[i].done));
        check($sformatf("tbl%0d_%0d_ack", pass, i),  32'(ack),  32'(tbl[i].ack));
        check($sformatf("tbl%0d_%0d_st", pass, i),   32'(st),   32'(tbl[i].st));
      end
      req = 1'b0;
    end

    // Soft re-sequence, requester drops req right after ack.
    req = 1'b1;
    step();
    e0 = ecnt;
    check("sr_dom0",  32'(dom),  32'd0);
    check("sr_done0", 32'(done), 32'd0);
    check("sr_st0",   32'(st),   32'd0);
    run_to(e0 + 55);
    check("sr_dom55", 32'(dom), 32'b011);
    check("sr_ack55", 32'(ack), 32'd0);
    step();
    check("sr_dom56",  32'(dom),  32'b111);
    check("sr_done56", 32'(done), 32'd1);
    check("sr_ack56",  32'(ack),  32'd1);
    check("sr_st56",   32'(st),   32'd2);
    req = 1'b0;
    step();
    check("sr_ack57", 32'(ack), 32'd0);
    check("sr_st57",  32'(st),  32'd2);

    // req held across the ack: a second sequence starts two edges later.
    req = 1'b1;
    step();
    e0 = ecnt;
    run_to(e0 + 56);
    check("hold_ack", 32'(ack), 32'd1);
    step();
    check("hold_st_a1",  32'(st),  32'd2);
    check("hold_ack_a1", 32'(ack), 32'd0);
    step();
    check("hold_st_a2",  32'(st),  32'd0);
    check("hold_dom_a2", 32'(dom), 32'd0);
    req = 1'b0;

    // Asynchronous reset in the middle of REL.
    fresh_start();
    run_to(30);
    check("ar_dom30", 32'(dom), 32'b001);
    #1;
    arstn = 1'b0;
    mdl_reset();
    #1;
    check("ar_dom_now", 32'(dom), 32'd0);
    check("ar_st_now",  32'(st),  32'd0);
    step();
    step();
    arstn = 1'b1;
    ecnt  = 0;
    run_to(23);
    check("ar_dom23", 32'(dom), 32'b000);
    run_to(24);
    check("ar_dom24", 32'(dom), 32'b001);
    run_to(56);
    check("ar_done56", 32'(done), 32'd1);

    // Single-domain, minimum-delay instance.
    arstn_b = 1'b1;
    step();
    check("b_st1",   32'(st_b),   32'd1);
    check("b_dom1",  32'(dom_b),  32'd0);
    check("b_done1", 32'(done_b), 32'd0);
    step();
    check("b_dom2",  32'(dom_b),  32'd1);
    check("b_done2", 32'(done_b), 32'd1);
    check("b_st2",   32'(st_b),   32'd2);
    check("b_ack2",  32'(ack_b),  32'd0);
    req_b = 1'b1;
    step();
    check("b_sr_dom0", 32'(dom_b), 32'd0);
    check("b_sr_st0",  32'(st_b),  32'd0);
    req_b = 1'b0;
    step();
    check("b_sr_st1", 32'(st_b), 32'd1);
    step();
    check("b_sr_dom2", 32'(dom_b), 32'd1);
    check("b_sr_ack2", 32'(ack_b), 32'd1);
    step();
    check("b_sr_ack3", 32'(ack_b), 32'd0);
    check("b_sr_dom3", 32'(dom_b), 32'd1);

    // Random requests, kicks and async reset pulses against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = ~req;
`ifdef RST_SEQ_WDT_EN
      kick = ($urandom_range(0, 119) == 0);
`endif
      if ($urandom_range(0, 599) == 0) begin
        arstn = 1'b0;
        mdl_reset();
        #1;
        chk_model();
        step();
        arstn = 1'b1;
      end
      step();
    end
    req = 1'b0;

`ifdef RST_SEQ_WDT_EN
    kick = 1'b0;
    fresh_start();
    run_to(56);
    for (int i = 0; i < 400; i++) begin
      kick = ((ecnt % 50) == 0);
      step();
    end
    kick = 1'b0;
    check("wdk_dom",   32'(dom),   32'b111);
    check("wdk_fired", 32'(fired), 32'd0);

    fresh_start();
    run_to(155);
    check("wd_dom155",   32'(dom),   32'b111);
    check("wd_fired155", 32'(fired), 32'd0);
    run_to(156);
    check("wd_dom156",   32'(dom),   32'b000);
    check("wd_fired156", 32'(fired), 32'd1);
    run_to(212);
    check("wd_dom212",   32'(dom),   32'b111);
    check("wd_done212",  32'(done),  32'd1);
    check("wd_ack212",   32'(ack),   32'd0);
    check("wd_fired212", 32'(fired), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
